// File: rtl/truth_table_capture_if.sv
// Capture-side bus for truth_table_capture: beat stream in, captured results out.
interface truth_table_capture_if #(
  parameter int unsigned N_IN  = 4,
  parameter int unsigned N_OUT = 2
);
  localparam int unsigned TW = N_OUT * (2 ** N_IN);

  logic            start;
  logic            vec_valid;
  logic [N_IN-1:0] vec_in;
  logic [N_OUT-1:0] resp_in;
  logic [TW-1:0]   exp_table;

  logic            busy;
  logic            done;
  logic [TW-1:0]   cap_table;
  logic [N_IN:0]   mismatch_cnt;
  logic            err_flag;
  logic [N_IN-1:0] first_err_idx;
  logic            seq_err;

  modport master (
    output start, vec_valid, vec_in, resp_in, exp_table,
    input  busy, done, cap_table, mismatch_cnt, err_flag, first_err_idx, seq_err
  );

  modport slave (
    input  start, vec_valid, vec_in, resp_in, exp_table,
    output busy, done, cap_table, mismatch_cnt, err_flag, first_err_idx, seq_err
  );
endinterface

// File: rtl/truth_table_capture.sv
// Captures a DUT's responses for every input vector and compares them against an expected table.
module truth_table_capture #(
  parameter int unsigned N_IN  = 4,
  parameter int unsigned N_OUT = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  truth_table_capture_if.slave bus
);
  localparam int unsigned DEPTH = 2 ** N_IN;
  localparam int unsigned TW    = N_OUT * DEPTH;
  localparam int unsigned OW    = $clog2(TW);
  localparam int unsigned CW    = N_IN + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [CW-1:0]   count_q, count_d;
  logic [TW-1:0]   cap_q, cap_d;
  logic [CW-1:0]   mis_q, mis_d;
  logic            err_q, err_d;
  logic [N_IN-1:0] first_q, first_d;
  logic            seq_q, seq_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [OW-1:0]   ofs_c;

  // Bit offset of the incoming vector's slot in the table.
  always_comb begin
    ofs_c = OW'(bus.vec_in) * OW'(N_OUT);
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      count_q <= '0;
      cap_q   <= '0;
      mis_q   <= '0;
      err_q   <= 1'b0;
      first_q <= '0;
      seq_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      cap_q   <= cap_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
      first_q <= first_d;
      seq_q   <= seq_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and result update; results hold unless a pass starts or a beat is accepted.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    count_d = count_q;
    cap_d   = cap_q;
    mis_d   = mis_q;
    first_d = first_q;
    seq_d   = seq_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_CAPTURE;
          idx_d   = '0;
          count_d = '0;
          cap_d   = '0;
          mis_d   = '0;
          first_d = '0;
          seq_d   = 1'b0;
        end
      end
      S_CAPTURE: begin
        if (bus.vec_valid) begin
          cap_d[ofs_c +: N_OUT] = bus.resp_in;
          if (bus.resp_in != bus.exp_table[ofs_c +: N_OUT]) begin
            mis_d = mis_q + CW'(1);
            if (mis_q == '0) begin
              first_d = bus.vec_in;
            end
          end
          if (bus.vec_in != idx_q) begin
            seq_d = 1'b1;
          end
          idx_d   = idx_q + N_IN'(1);
          count_d = count_q + CW'(1);
          if (count_q == CW'(DEPTH - 1)) begin
            state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_CAPTURE);
    done_d = (state_d == S_DONE);
    err_d  = (mis_d != '0);
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.cap_table     = cap_q;
  assign bus.mismatch_cnt  = mis_q;
  assign bus.err_flag      = err_q;
  assign bus.first_err_idx = first_q;
  assign bus.seq_err       = seq_q;
endmodule
